// File: rtl/edicion_campos_rtc_if.sv
// edicion_campos_rtc_if
// Groups the front-panel buttons, mode inputs, RTC readback and edited values
// that pass between the time/date editor and its environment.
//   master : environment side (drives buttons, modes, readback; sees results)
//   slave  : editor side (sees buttons, modes, readback; drives results)
interface edicion_campos_rtc_if;
  logic       btn_editar;
  logic       btn_arriba;
  logic       btn_abajo;
  logic       btn_izq;
  logic       btn_der;
  logic       sel_ct;
  logic       doce_24;
  logic [7:0] Seg_in;
  logic [7:0] Min_in;
  logic [7:0] Hora_in;
  logic [7:0] Dia_in;
  logic [7:0] Mes_in;
  logic [7:0] Ano_in;
  logic [7:0] clk_seg;
  logic [7:0] clk_min;
  logic [7:0] clk_hora;
  logic [7:0] Dia;
  logic [7:0] Mes;
  logic [7:0] Ano;
  logic       CT;
  logic       WR;
  logic       editando;
  logic [2:0] campo;

  modport master (
    output btn_editar, btn_arriba, btn_abajo, btn_izq, btn_der,
    output sel_ct, doce_24,
    output Seg_in, Min_in, Hora_in, Dia_in, Mes_in, Ano_in,
    input  clk_seg, clk_min, clk_hora, Dia, Mes, Ano,
    input  CT, WR, editando, campo
  );

  modport slave (
    input  btn_editar, btn_arriba, btn_abajo, btn_izq, btn_der,
    input  sel_ct, doce_24,
    input  Seg_in, Min_in, Hora_in, Dia_in, Mes_in, Ano_in,
    output clk_seg, clk_min, clk_hora, Dia, Mes, Ano,
    output CT, WR, editando, campo
  );
endinterface

// File: rtl/edicion_campos_rtc.sv
// edicion_campos_rtc
// Button-driven BCD time/date editor feeding the RTC write machine.
// Debounces five buttons, loads the RTC readback, edits one field at a time
// with range-correct wrap, and issues a one-cycle WR on commit.
// Ports:
//   CLK   : system clock
//   Reset : asynchronous, active-high reset
//   bus   : edicion_campos_rtc_if.slave (buttons, modes, readback, results)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for an editar press
// CARGA   | one cycle: latch sel_ct, load sanitised readback
// EDITA   | editing fields; editar commits, inactivity aborts
// COMMIT  | one cycle: WR asserted
module edicion_campos_rtc #(
  parameter int DEB_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input logic                    CLK,
  input logic                    Reset,
  edicion_campos_rtc_if.slave    bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CARGA, S_EDITA, S_COMMIT} state_t;

  // ---------------- button conditioning ----------------
  // bit 4 editar, 3 arriba, 2 abajo, 1 izq, 0 der
  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync2_q;
  logic [DW-1:0] deb_q [5];
  logic [4:0]    press;

  assign btn_raw = {bus.btn_editar, bus.btn_arriba, bus.btn_abajo, bus.btn_izq, bus.btn_der};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 5; i++) deb_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 5; i++) begin
        if (!sync2_q[i])
          deb_q[i] <= '0;
        else if (deb_q[i] != DW'(DEB_CYCLES))
          deb_q[i] <= deb_q[i] + DW'(1);  // saturates: one pulse per press
      end
    end
  end

  // Pulse on the cycle the counter steps onto DEB_CYCLES.
  always_comb begin
    press = '0;
    for (int i = 0; i < 5; i++)
      press[i] = sync2_q[i] && (deb_q[i] == DW'(DEB_CYCLES - 1));
  end

  // ---------------- BCD range helpers ----------------
  function automatic logic [6:0] rng_min(input logic [2:0] f, input logic hr12);
    case (f)
      3'd2:       rng_min = hr12 ? 7'd1 : 7'd0;
      3'd3, 3'd4: rng_min = 7'd1;
      default:    rng_min = 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] rng_max(input logic [2:0] f, input logic hr12);
    case (f)
      3'd0, 3'd1: rng_max = 7'd59;
      3'd2:       rng_max = hr12 ? 7'd12 : 7'd23;
      3'd3:       rng_max = 7'd31;
      3'd4:       rng_max = 7'd12;
      default:    rng_max = 7'd99;
    endcase
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    bcd2bin = 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    bin2bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic valid_bcd(input logic [7:0] b, input logic [6:0] mn,
                                     input logic [6:0] mx);
    valid_bcd = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) &&
                (bcd2bin(b) >= mn) && (bcd2bin(b) <= mx);
  endfunction

  // Out-of-range values (e.g. hour after a 12/24 switch) clamp to min before stepping.
  function automatic logic [7:0] bcd_step(input logic [7:0] b, input logic [2:0] f,
                                          input logic hr12, input logic up);
    logic [6:0] mn, mx, v;
    mn = rng_min(f, hr12);
    mx = rng_max(f, hr12);
    v  = valid_bcd(b, mn, mx) ? bcd2bin(b) : mn;
    if (up) v = (v == mx) ? mn : v + 7'd1;
    else    v = (v == mn) ? mx : v - 7'd1;
    bcd_step = bin2bcd(v);
  endfunction

  // ---------------- FSM ----------------
  state_t        state_q, state_d;
  logic [7:0]    fld_q [6];
  logic [7:0]    fld_d [6];
  logic [7:0]    fin   [6];
  logic          ct_q, ct_d;
  logic [2:0]    campo_q, campo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          hr12_edit, hr12_load;
  logic [2:0]    last_campo;

  assign fin[0] = bus.Seg_in;
  assign fin[1] = bus.Min_in;
  assign fin[2] = bus.Hora_in;
  assign fin[3] = bus.Dia_in;
  assign fin[4] = bus.Mes_in;
  assign fin[5] = bus.Ano_in;

  // Timer hours are always 00-23.
  assign hr12_edit  = !ct_q && bus.doce_24;
  assign hr12_load  = !bus.sel_ct && bus.doce_24;
  assign last_campo = ct_q ? 3'd2 : 3'd5;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 6; i++) fld_q[i] <= 8'h00;
      ct_q    <= 1'b0;
      campo_q <= 3'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      ct_q    <= ct_d;
      campo_q <= campo_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    ct_d    = ct_q;
    campo_d = campo_q;
    tmo_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (press[4]) state_d = S_CARGA;
      end
      S_CARGA: begin
        ct_d    = bus.sel_ct;
        campo_d = 3'd0;
        for (int i = 0; i < 6; i++) begin
          if (valid_bcd(fin[i], rng_min(3'(i), hr12_load), rng_max(3'(i), hr12_load)))
            fld_d[i] = fin[i];
          else
            fld_d[i] = bin2bcd(rng_min(3'(i), hr12_load));
        end
        state_d = S_EDITA;
      end
      S_EDITA: begin
        tmo_d = (|press) ? '0 : tmo_q + TW'(1);
        // Fixed priority: only the highest pulse this cycle acts.
        if (press[4]) begin
          state_d = S_COMMIT;
        end else if (press[3] || press[2]) begin
          for (int i = 0; i < 6; i++)
            if (campo_q == 3'(i))
              fld_d[i] = bcd_step(fld_q[i], 3'(i), hr12_edit, press[3]);
        end else if (press[1]) begin
          campo_d = (campo_q == 3'd0) ? last_campo : campo_q - 3'd1;
        end else if (press[0]) begin
          campo_d = (campo_q == last_campo) ? 3'd0 : campo_q + 3'd1;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.clk_seg  = fld_q[0];
  assign bus.clk_min  = fld_q[1];
  assign bus.clk_hora = fld_q[2];
  assign bus.Dia      = fld_q[3];
  assign bus.Mes      = fld_q[4];
  assign bus.Ano      = fld_q[5];
  assign bus.CT       = ct_q;
  assign bus.WR       = (state_q == S_COMMIT);
  assign bus.editando = (state_q == S_CARGA) || (state_q == S_EDITA);
  assign bus.campo    = campo_q;

endmodule

// File: tb/tb_edicion_campos_rtc.sv
// tb_edicion_campos_rtc
// Drives the editor through directed and random edit sessions. Expected commit
// records go into a queue; a monitor pops and compares them on every WR.
module tb_edicion_campos_rtc;
  localparam int DEB = 4;
  localparam int TMO = 100;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  edicion_campos_rtc_if bus();

  edicion_campos_rtc #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [47:0] f;
    logic        ct;
  } commit_t;

  commit_t    exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_val [6];
  bit         m_ct;
  int         m_campo;
  logic       wr_prev = 1'b0;

  // ---------------- reference model helpers ----------------
  function automatic int lo_of(int f, bit hr12);
    if (f == 3 || f == 4) return 1;
    if (f == 2 && hr12) return 1;
    return 0;
  endfunction

  function automatic int hi_of(int f, bit hr12);
    case (f)
      0, 1: return 59;
      2: return hr12 ? 12 : 23;
      3: return 31;
      4: return 12;
      default: return 99;
    endcase
  endfunction

  function automatic int val_of(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit ok(logic [7:0] b, int lo, int hi);
    return (b[7:4] < 10) && (b[3:0] < 10) && (val_of(b) >= lo) && (val_of(b) <= hi);
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] dut_fld(int i);
    case (i)
      0: return bus.clk_seg;
      1: return bus.clk_min;
      2: return bus.clk_hora;
      3: return bus.Dia;
      4: return bus.Mes;
      default: return bus.Ano;
    endcase
  endfunction

  function automatic logic [7:0] tb_in(int i);
    case (i)
      0: return bus.Seg_in;
      1: return bus.Min_in;
      2: return bus.Hora_in;
      3: return bus.Dia_in;
      4: return bus.Mes_in;
      default: return bus.Ano_in;
    endcase
  endfunction

  task automatic set_in(int i, logic [7:0] v);
    case (i)
      0: bus.Seg_in  = v;
      1: bus.Min_in  = v;
      2: bus.Hora_in = v;
      3: bus.Dia_in  = v;
      4: bus.Mes_in  = v;
      default: bus.Ano_in = v;
    endcase
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  // 0 editar, 1 arriba, 2 abajo, 3 izq, 4 der, 5 editar+arriba together
  task automatic set_btn(int w, logic v);
    case (w)
      0: bus.btn_editar = v;
      1: bus.btn_arriba = v;
      2: bus.btn_abajo  = v;
      3: bus.btn_izq    = v;
      4: bus.btn_der    = v;
      default: begin
        bus.btn_editar = v;
        bus.btn_arriba = v;
      end
    endcase
  endtask

  task automatic press(int w);
    set_btn(w, 1'b1);
    cyc(8);
    set_btn(w, 1'b0);
    cyc(6);
  endtask

  task automatic m_step(bit up);
    bit hr12;
    int lo, hi, v;
    hr12 = !m_ct && bus.doce_24;
    lo = lo_of(m_campo, hr12);
    hi = hi_of(m_campo, hr12);
    v  = ok(m_val[m_campo], lo, hi) ? val_of(m_val[m_campo]) : lo;
    if (up) v = (v == hi) ? lo : v + 1;
    else    v = (v == lo) ? hi : v - 1;
    m_val[m_campo] = to_bcd(v);
  endtask

  task automatic enter_edit();
    bit hr12;
    hr12 = !bus.sel_ct && bus.doce_24;
    press(0);
    m_ct = bus.sel_ct;
    m_campo = 0;
    for (int f = 0; f < 6; f++)
      m_val[f] = ok(tb_in(f), lo_of(f, hr12), hi_of(f, hr12)) ? tb_in(f) : to_bcd(lo_of(f, hr12));
    chk("editando_on_entry", bus.editando, 1);
    for (int f = 0; f < 6; f++) chk($sformatf("load_f%0d", f), dut_fld(f), m_val[f]);
    chk("campo_on_entry", bus.campo, 0);
  endtask

  task automatic do_op(int op);
    int last;
    last = m_ct ? 2 : 5;
    press(op);
    case (op)
      1: m_step(1'b1);
      2: m_step(1'b0);
      3: m_campo = (m_campo == 0) ? last : m_campo - 1;
      default: m_campo = (m_campo == last) ? 0 : m_campo + 1;
    endcase
    chk("campo", bus.campo, m_campo);
    chk($sformatf("edit_f%0d", m_campo), dut_fld(m_campo), m_val[m_campo]);
  endtask

  task automatic push_expected();
    commit_t e;
    for (int i = 0; i < 6; i++) e.f[i*8 +: 8] = m_val[i];
    e.ct = m_ct;
    exp_q.push_back(e);
  endtask

  task automatic commit();
    push_expected();
    press(0);
    chk("editando_after_commit", bus.editando, 0);
  endtask

  task automatic rand_inputs(bit wild);
    bit hr12;
    hr12 = !bus.sel_ct && bus.doce_24;
    for (int f = 0; f < 6; f++) begin
      if (wild && ($urandom_range(0, 3) == 0))
        set_in(f, 8'($urandom_range(0, 255)));
      else
        set_in(f, to_bcd($urandom_range(lo_of(f, hr12), hi_of(f, hr12))));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    commit_t e;
    if (wr_prev) begin
      chk("wr_one_cycle", bus.WR, 0);
      chk("editando_after_wr", bus.editando, 0);
    end
    if (bus.WR) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < 6; i++)
          chk($sformatf("commit_f%0d", i), dut_fld(i), e.f[i*8 +: 8]);
        chk("commit_ct", bus.CT, e.ct);
      end
    end
    wr_prev <= bus.WR;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit done;
    bus.btn_editar = 0; bus.btn_arriba = 0; bus.btn_abajo = 0;
    bus.btn_izq = 0; bus.btn_der = 0;
    bus.sel_ct = 0; bus.doce_24 = 0;
    for (int f = 0; f < 6; f++) set_in(f, 8'h00);
    Reset = 1'b1;
    cyc(3);
    for (int f = 0; f < 6; f++) chk($sformatf("reset_f%0d", f), dut_fld(f), 0);
    chk("reset_ct", bus.CT, 0);
    chk("reset_wr", bus.WR, 0);
    chk("reset_editando", bus.editando, 0);
    chk("reset_campo", bus.campo, 0);
    Reset = 1'b0;
    cyc(2);

    // idle presses other than editar do nothing
    press(1);
    chk("idle_ignores_arriba", bus.editando, 0);

    // clock edit with seconds and hour wrap
    rand_inputs(0);
    bus.Seg_in = 8'h58; bus.Hora_in = 8'h00;
    enter_edit();
    do_op(1);
    do_op(1);
    chk("seg_58_plus2", bus.clk_seg, 8'h00);
    do_op(4);
    do_op(4);
    do_op(2);
    chk("hora_00_minus1", bus.clk_hora, 8'h23);
    commit();

    // debounce: short pulse, glitched hold, long hold
    rand_inputs(0);
    enter_edit();
    set_btn(1, 1); cyc(3); set_btn(1, 0); cyc(6);
    chk("deb_short", bus.clk_seg, m_val[0]);
    set_btn(1, 1); cyc(3); set_btn(1, 0); cyc(1); set_btn(1, 1); cyc(3); set_btn(1, 0); cyc(6);
    chk("deb_glitch", bus.clk_seg, m_val[0]);
    set_btn(1, 1); cyc(20); set_btn(1, 0); cyc(6);
    m_step(1'b1);
    chk("deb_long_hold", bus.clk_seg, m_val[0]);
    commit();

    // 12-hour and date wraps
    bus.doce_24 = 1;
    rand_inputs(0);
    bus.Hora_in = 8'h12; bus.Dia_in = 8'h31; bus.Mes_in = 8'h01; bus.Ano_in = 8'h99;
    enter_edit();
    do_op(4); do_op(4); do_op(1);
    chk("hora12_wrap", bus.clk_hora, 8'h01);
    do_op(4); do_op(1);
    chk("dia_wrap", bus.Dia, 8'h01);
    do_op(4); do_op(2);
    chk("mes_wrap", bus.Mes, 8'h12);
    do_op(4); do_op(1);
    chk("ano_wrap", bus.Ano, 8'h00);
    commit();
    bus.Hora_in = 8'h00;
    enter_edit();
    chk("hora12_load_clamp", bus.clk_hora, 8'h01);
    commit();
    bus.doce_24 = 0;

    // timer mode field stepping
    bus.sel_ct = 1;
    rand_inputs(0);
    enter_edit();
    do_op(4); chk("timer_campo1", bus.campo, 1);
    do_op(4); chk("timer_campo2", bus.campo, 2);
    do_op(4); chk("timer_campo0", bus.campo, 0);
    do_op(3); chk("timer_izq_wrap", bus.campo, 2);
    do_op(1);
    commit();
    bus.sel_ct = 0;

    // editar beats arriba in the same cycle
    rand_inputs(0);
    enter_edit();
    push_expected();
    press(5);
    chk("priority_commit", bus.editando, 0);

    // inactivity timeout
    rand_inputs(0);
    enter_edit();
    do_op(1);
    cyc(75);
    chk("timeout_not_early", bus.editando, 1);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc(1);
      if (!bus.editando) done = 1;
    end
    chk("timeout_reached", done, 1);
    for (int f = 0; f < 6; f++) chk($sformatf("timeout_keep_f%0d", f), dut_fld(f), m_val[f]);

    // random sessions, including illegal readback and 12/24 switches
    for (int s = 0; s < 8; s++) begin
      bus.sel_ct  = $urandom_range(0, 1);
      bus.doce_24 = $urandom_range(0, 1);
      rand_inputs(1);
      enter_edit();
      repeat ($urandom_range(8, 16)) begin
        if ($urandom_range(0, 5) == 0) bus.doce_24 = ~bus.doce_24;
        do_op($urandom_range(1, 4));
      end
      commit();
    end
    bus.sel_ct = 0; bus.doce_24 = 0;

    // reset in the middle of an edit
    rand_inputs(0);
    enter_edit();
    do_op(1);
    do_op(4);
    Reset = 1'b1;
    cyc(1);
    for (int f = 0; f < 6; f++) chk($sformatf("midreset_f%0d", f), dut_fld(f), 0);
    chk("midreset_campo", bus.campo, 0);
    chk("midreset_editando", bus.editando, 0);
    chk("midreset_ct", bus.CT, 0);
    Reset = 1'b0;
    cyc(3);
    chk("after_reset_editando", bus.editando, 0);

    cyc(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
